// File: rtl/f1_lights_seq.sv
// Start-light sequencer: fills N_LIGHTS lamps on en ticks, holds for an LFSR-random time, then pulses go.
// Define F1_FALSE_START_EN to abort on a trigger rise while busy and raise a sticky false_start flag.
module f1_lights_seq #(
  parameter int          N_LIGHTS  = 8,
  parameter int          HOLD_W    = 4,
  parameter int          MIN_HOLD  = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                trigger,
  output logic [N_LIGHTS-1:0] data_out,
  output logic                cmd_seq,
  output logic                cmd_delay,
  output logic                go,
  output logic                busy,
  output logic                false_start,
  output logic [1:0]          o_state
);

  localparam int                CNT_W      = $clog2(N_LIGHTS + 1);
  localparam logic [CNT_W-1:0]  C_N_LIGHTS = CNT_W'(N_LIGHTS);
  localparam logic [HOLD_W:0]   C_MIN_HOLD = (HOLD_W + 1)'(MIN_HOLD);
  localparam logic [N_LIGHTS-1:0] C_FIRST  = {{(N_LIGHTS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t              r_state;
  logic [N_LIGHTS-1:0] r_data;
  logic                r_cmd_seq;
  logic                r_cmd_delay;
  logic                r_go;
  logic                r_busy;
  logic                r_trig_q;
  logic                r_armed;
  logic [CNT_W-1:0]    r_count;
  logic [HOLD_W:0]     r_hold;
  logic [15:0]         r_lfsr;
  logic                w_rise;
  logic                w_fb;

  assign w_rise = trigger & ~r_trig_q;
  // Polynomial x^16 + x^14 + x^13 + x^11 + 1 (maximal length, never reaches zero).
  assign w_fb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  assign data_out  = r_data;
  assign cmd_seq   = r_cmd_seq;
  assign cmd_delay = r_cmd_delay;
  assign go        = r_go;
  assign busy      = r_busy;
  assign o_state   = r_state;

`ifdef F1_FALSE_START_EN
  logic r_false_start;
  assign false_start = r_false_start;
`else
  assign false_start = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_data      <= '0;
      r_cmd_seq   <= 1'b0;
      r_cmd_delay <= 1'b0;
      r_go        <= 1'b0;
      r_busy      <= 1'b0;
      r_trig_q    <= 1'b0;
      r_armed     <= 1'b0;
      r_count     <= '0;
      r_hold      <= '0;
      r_lfsr      <= LFSR_SEED;
`ifdef F1_FALSE_START_EN
      r_false_start <= 1'b0;
`endif
    end else begin
      r_trig_q <= trigger;
      r_lfsr   <= {r_lfsr[14:0], w_fb};
      r_go     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_rise && r_armed) begin
            r_state   <= S_FILL;
            r_data    <= C_FIRST;
            r_count   <= CNT_W'(1);
            r_cmd_seq <= 1'b1;
            r_busy    <= 1'b1;
            r_armed   <= 1'b0;
`ifdef F1_FALSE_START_EN
            r_false_start <= 1'b0;
`endif
          end else if (!trigger) begin
            r_armed <= 1'b1;
          end
        end
        S_FILL: begin
`ifdef F1_FALSE_START_EN
          if (w_rise) begin
            r_state       <= S_IDLE;
            r_data        <= '0;
            r_cmd_seq     <= 1'b0;
            r_busy        <= 1'b0;
            r_false_start <= 1'b1;
          end else
`endif
          if (en) begin
            if (r_count < C_N_LIGHTS) begin
              r_data  <= {r_data[N_LIGHTS-2:0], 1'b1};
              r_count <= r_count + CNT_W'(1);
            end else begin
              // The hold draw uses the LFSR value present in this cycle.
              r_state     <= S_HOLD;
              r_hold      <= C_MIN_HOLD + {1'b0, r_lfsr[HOLD_W-1:0]};
              r_cmd_seq   <= 1'b0;
              r_cmd_delay <= 1'b1;
            end
          end
        end
        S_HOLD: begin
`ifdef F1_FALSE_START_EN
          if (w_rise) begin
            r_state       <= S_IDLE;
            r_data        <= '0;
            r_cmd_delay   <= 1'b0;
            r_busy        <= 1'b0;
            r_false_start <= 1'b1;
          end else
`endif
          if (en) begin
            if (r_hold != '0) begin
              r_hold <= r_hold - (HOLD_W + 1)'(1);
            end else begin
              r_state     <= S_IDLE;
              r_data      <= '0;
              r_cmd_delay <= 1'b0;
              r_busy      <= 1'b0;
              r_go        <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
